// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: datapath width, writeback source selects
// and load funct3 encodings.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/load_extract.sv
// Combinational load data extraction: picks the byte/half/word out of an
// aligned memory word and sign- or zero-extends it by funct3.
module load_extract
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // addr_lo[0] is ignored for halves; misaligned loads trap upstream.
  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    value = '0;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   value = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LW:   value = rdata;
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_v};
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM/WB fields and drives the register file write
// port. Define WB_INSTRET_EN to build the retired-instruction counter.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_we,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_res,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [XLEN-1:0]  in_pc_plus4,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);

  import riscv_pkg::*;

  logic            valid_q;
  logic            we_q;
  logic [4:0]      rd_q;
  logic [1:0]      wb_sel_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] load_val;

  // flush only kills the instruction being captured on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      wb_sel_q  <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      alu_q     <= '0;
      rdata_q   <= '0;
      pc4_q     <= '0;
    end else begin
      valid_q   <= in_valid & ~flush;
      we_q      <= in_we;
      rd_q      <= in_rd;
      wb_sel_q  <= in_wb_sel;
      funct3_q  <= in_funct3;
      addr_lo_q <= in_addr_lo;
      alu_q     <= in_alu_res;
      rdata_q   <= in_mem_rdata;
      pc4_q     <= in_pc_plus4;
    end
  end

  load_extract u_load_extract (
    .rdata   (rdata_q),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .value   (load_val)
  );

  always_comb begin
    rf_wdata = '0;
    case (wb_sel_q)
      WB_SEL_ALU: rf_wdata = alu_q;
      WB_SEL_MEM: rf_wdata = load_val;
      WB_SEL_PC4: rf_wdata = pc4_q;
      default:    rf_wdata = '0;
    endcase
  end

  // x0 is gated here as well as in the register file.
  assign rf_we    = valid_q & we_q & (rd_q != 5'd0);
  assign rf_rd    = rd_q;
  assign wb_valid = valid_q;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt_q <= '0;
    else if (valid_q) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instret = cnt_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; with WB_INSTRET_EN defined the
// counter is built 4 bits wide so the wrap can be reached quickly.
module tb_wb_stage;

`ifdef WB_INSTRET_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 64;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                in_valid;
  logic                in_we;
  logic [4:0]          in_rd;
  logic [1:0]          in_wb_sel;
  logic [2:0]          in_funct3;
  logic [1:0]          in_addr_lo;
  logic [31:0]         in_alu_res;
  logic [31:0]         in_mem_rdata;
  logic [31:0]         in_pc_plus4;
  logic                rf_we;
  logic [4:0]          rf_rd;
  logic [31:0]         rf_wdata;
  logic                wb_valid;
  logic [TB_CNT_W-1:0] instret;

  int tests = 0;
  int fails = 0;

  wb_stage #(.XLEN(32), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_we        (in_we),
    .in_rd        (in_rd),
    .in_wb_sel    (in_wb_sel),
    .in_funct3    (in_funct3),
    .in_addr_lo   (in_addr_lo),
    .in_alu_res   (in_alu_res),
    .in_mem_rdata (in_mem_rdata),
    .in_pc_plus4  (in_pc_plus4),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .wb_valid     (wb_valid),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] alo,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4);
    in_valid     = v;
    flush        = f;
    in_we        = we;
    in_rd        = rd;
    in_wb_sel    = sel;
    in_funct3    = f3;
    in_addr_lo   = alo;
    in_alu_res   = alu;
    in_mem_rdata = rdata;
    in_pc_plus4  = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  ld_f3  [9];
  logic [1:0]  ld_alo [9];
  logic [31:0] ld_exp [9];
  logic [12:0] vpat;
  logic [12:0] fpat;

  initial begin
    ld_f3[0] = 3'd0; ld_alo[0] = 2'd1; ld_exp[0] = 32'h0000007F;
    ld_f3[1] = 3'd0; ld_alo[1] = 2'd3; ld_exp[1] = 32'hFFFFFF80;
    ld_f3[2] = 3'd4; ld_alo[2] = 2'd2; ld_exp[2] = 32'h000000FF;
    ld_f3[3] = 3'd1; ld_alo[3] = 2'd2; ld_exp[3] = 32'hFFFF80FF;
    ld_f3[4] = 3'd5; ld_alo[4] = 2'd0; ld_exp[4] = 32'h00007F01;
    ld_f3[5] = 3'd2; ld_alo[5] = 2'd1; ld_exp[5] = 32'h80FF7F01;
    ld_f3[6] = 3'd3; ld_alo[6] = 2'd0; ld_exp[6] = 32'h00000000;
    ld_f3[7] = 3'd4; ld_alo[7] = 2'd3; ld_exp[7] = 32'h00000080;
    ld_f3[8] = 3'd1; ld_alo[8] = 2'd0; ld_exp[8] = 32'h00007F01;

    rst = 1'b1;
    drive(1, 0, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    #12;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_rd", rf_rd, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_instret", instret, 0);

    rst = 1'b0;
    drive(1, 0, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h12345678, 32'h0, 32'h0);
    tick();
    chk("alu_rf_we", rf_we, 1);
    chk("alu_rf_rd", rf_rd, 5);
    chk("alu_rf_wdata", rf_wdata, 32'h12345678);
    chk("alu_wb_valid", wb_valid, 1);

    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1, 5'd3, 2'd1, ld_f3[i], ld_alo[i], 32'h55555555, 32'h80FF7F01, 32'h0);
      tick();
      chk($sformatf("load_%0d_wdata", i), rf_wdata, ld_exp[i]);
    end
    chk("load_rf_we", rf_we, 1);

    drive(1, 0, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'hCAFE0000, 32'h0, 32'h0);
    tick();
    chk("x0_rf_we", rf_we, 0);
    chk("x0_wb_valid", wb_valid, 1);

    drive(1, 0, 1, 5'd1, 2'd2, 3'd0, 2'd0, 32'h11111111, 32'h0, 32'h104);
    tick();
    chk("jal_rf_we", rf_we, 1);
    chk("jal_rf_rd", rf_rd, 1);
    chk("jal_rf_wdata", rf_wdata, 32'h104);

    drive(1, 0, 1, 5'd2, 2'd3, 3'd0, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333);
    tick();
    chk("sel3_rf_wdata", rf_wdata, 0);

    drive(1, 0, 0, 5'd4, 2'd0, 3'd0, 2'd0, 32'h44444444, 32'h0, 32'h0);
    tick();
    chk("nowe_rf_we", rf_we, 0);
    chk("nowe_wb_valid", wb_valid, 1);

    drive(1, 0, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h000000AA, 32'h0, 32'h0);
    tick();
    drive(1, 1, 1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h000000BB, 32'h0, 32'h0);
    #1;
    chk("flush_inwb_rf_we", rf_we, 1);
    chk("flush_inwb_wdata", rf_wdata, 32'h000000AA);
    tick();
    chk("flush_wb_valid", wb_valid, 0);
    chk("flush_rf_we", rf_we, 0);

    drive(0, 0, 1, 5'd6, 2'd0, 3'd0, 2'd0, 32'h66666666, 32'h0, 32'h0);
    tick();
    chk("bubble_wb_valid", wb_valid, 0);
    chk("bubble_rf_we", rf_we, 0);

    drive(1, 0, 1, 5'd10, 2'd0, 3'd0, 2'd0, 32'h0000A5A5, 32'h0, 32'h0);
    tick();
    chk("pre_rst_rf_we", rf_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rf_we", rf_we, 0);
    chk("async_rst_rf_wdata", rf_wdata, 0);
    chk("async_rst_wb_valid", wb_valid, 0);
    chk("async_rst_instret", instret, 0);
    #2 rst = 1'b0;
    drive(1, 0, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h0BADF00D, 32'h0, 32'h0);
    tick();
    chk("post_rst_rf_we", rf_we, 1);
    chk("post_rst_wdata", rf_wdata, 32'h0BADF00D);

    // Counter run from a clean reset: 10 valid presentations, 2 flushed, 3 bubbles.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    vpat = 13'b1101101111011;
    fpat = 13'b0001000010000;
    for (int i = 0; i < 13; i++) begin
      drive(vpat[i], fpat[i], 1, 5'd1, 2'd0, 3'd0, 2'd0, 32'(i), 32'h0, 32'h0);
      tick();
    end
    drive(0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    tick();
`ifdef WB_INSTRET_EN
    chk("instret_count", instret, 8);
`else
    chk("instret_tied0", instret, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 5'd1, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
      tick();
    end
`ifdef WB_INSTRET_EN
    chk("instret_all_ones", instret, 15);
`else
    chk("instret_still0", instret, 0);
`endif
    drive(0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("instret_wrap", instret, 0);
    chk("idle_wb_valid", wb_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
